// File: rtl/btn_led_pkg.sv
// rtl/btn_led_pkg.sv - shared mode encoding, defaults and LED next-state rule for the button/LED bank
package btn_led_pkg;

    typedef enum logic {
        MODE_TOGGLE    = 1'b0,
        MODE_MOMENTARY = 1'b1
    } mode_e;

    localparam int DB_CYCLES_DEFAULT = 50000;

    // Momentary follows the debounced level and ignores clear; clear wins over a toggle press.
    function automatic logic led_next(
        input mode_e mode,
        input logic  cur,
        input logic  down,
        input logic  press,
        input logic  clr
    );
        if (mode == MODE_MOMENTARY) begin
            return down;
        end
        if (clr) begin
            return 1'b0;
        end
        if (press) begin
            return ~cur;
        end
        return cur;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - one channel: 2-flop synchroniser, stability counter, level and edge pulses
module btn_debounce
    import btn_led_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_n,
    output logic o_down,
    output logic o_press_p,
    output logic o_release_p
);

    localparam int                CNT_W   = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             btn_s;
    logic [CNT_W-1:0] cnt;

    assign btn_s = ~sync2;

    // Counter only runs while the synchronised input disagrees with the accepted level,
    // so any disagreement shorter than DB_CYCLES is discarded without a trace.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            cnt         <= '0;
            o_down      <= 1'b0;
            o_press_p   <= 1'b0;
            o_release_p <= 1'b0;
        end else begin
            sync1       <= i_btn_n;
            sync2       <= sync1;
            o_press_p   <= 1'b0;
            o_release_p <= 1'b0;
            if (btn_s == o_down) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                o_down      <= btn_s;
                cnt         <= '0;
                o_press_p   <= btn_s;
                o_release_p <= ~btn_s;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/btn_led_bank.sv
// rtl/btn_led_bank.sv - N-channel debounced buttons driving per-channel toggle/momentary LEDs
module btn_led_bank
    import btn_led_pkg::*;
#(
    parameter int N_CH           = 4,
    parameter int DB_CYCLES      = DB_CYCLES_DEFAULT,
    parameter bit LED_ACTIVE_LOW = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [N_CH-1:0] i_btn_n,
    input  logic [N_CH-1:0] i_mode,
    input  logic            i_clr,
    output logic [N_CH-1:0] o_led,
    output logic [N_CH-1:0] o_btn_down,
    output logic [N_CH-1:0] o_press_p,
    output logic [N_CH-1:0] o_release_p
);

    localparam logic [N_CH-1:0] LED_POL = {N_CH{LED_ACTIVE_LOW}};

    logic [N_CH-1:0] led_on;
    logic [N_CH-1:0] led_on_next;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        btn_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .i_clk       (i_clk),
            .i_rst_n     (i_rst_n),
            .i_btn_n     (i_btn_n[g]),
            .o_down      (o_btn_down[g]),
            .o_press_p   (o_press_p[g]),
            .o_release_p (o_release_p[g])
        );
    end

    always_comb begin
        led_on_next = '0;
        for (int i = 0; i < N_CH; i++) begin
            led_on_next[i] = led_next(mode_e'(i_mode[i]), led_on[i], o_btn_down[i],
                                      o_press_p[i], i_clr);
        end
    end

    // Pin register is loaded from the same next-state as led_on so the two never disagree.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            led_on <= '0;
            o_led  <= LED_POL;
        end else begin
            led_on <= led_on_next;
            o_led  <= led_on_next ^ LED_POL;
        end
    end

endmodule

// File: tb/tb_btn_led_bank.sv
// tb/tb_btn_led_bank.sv - scoreboard bench for btn_led_bank with a sliding-window reference model
module tb_btn_led_bank;

    localparam int N  = 4;
    localparam int DB = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] btn_n;
    logic [N-1:0] mode;
    logic         clr;
    logic [N-1:0] led;
    logic [N-1:0] down;
    logic [N-1:0] press;
    logic [N-1:0] rel;

    always #5 clk = ~clk;

    btn_led_bank #(
        .N_CH           (N),
        .DB_CYCLES      (DB),
        .LED_ACTIVE_LOW (1'b1)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_btn_n     (btn_n),
        .i_mode      (mode),
        .i_clr       (clr),
        .o_led       (led),
        .o_btn_down  (down),
        .o_press_p   (press),
        .o_release_p (rel)
    );

    typedef struct packed {
        logic [N-1:0] led;
        logic [N-1:0] down;
        logic [N-1:0] press;
        logic [N-1:0] rel;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   press_cnt[N];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
        end
    endtask

    // Reference model: a new level is accepted once the last DB synchronised samples
    // (raw samples delayed two edges) all disagree with the current level.
    bit   hist[N][$];
    bit   m_down[N];
    bit   m_press[N];
    bit   m_led[N];
    bit   flip;
    exp_t e;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            for (int i = 0; i < N; i++) begin
                m_down[i]  = 1'b0;
                m_press[i] = 1'b0;
                m_led[i]   = 1'b0;
                hist[i].delete();
                for (int j = 0; j < DB + 2; j++) hist[i].push_back(1'b0);
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (mode[i])           m_led[i] = m_down[i];
                else if (clr)          m_led[i] = 1'b0;
                else if (m_press[i])   m_led[i] = ~m_led[i];
                hist[i].push_front(~btn_n[i]);
                void'(hist[i].pop_back());
                flip = 1'b1;
                for (int j = 2; j < DB + 2; j++) begin
                    if (hist[i][j] == m_down[i]) flip = 1'b0;
                end
                m_press[i] = flip && !m_down[i];
                e.press[i] = m_press[i];
                e.rel[i]   = flip && m_down[i];
                if (flip) m_down[i] = ~m_down[i];
                e.down[i]  = m_down[i];
                e.led[i]   = ~m_led[i];
            end
            exp_q.push_back(e);
        end
    end

    exp_t got;
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs", {led, down, press, rel}, {4'hF, 12'h000});
        end else if (exp_q.size() > 0) begin
            got = exp_q.pop_front();
            chk("led",     {12'h0, led},   {12'h0, got.led});
            chk("down",    {12'h0, down},  {12'h0, got.down});
            chk("press_p", {12'h0, press}, {12'h0, got.press});
            chk("release", {12'h0, rel},   {12'h0, got.rel});
            for (int i = 0; i < N; i++) press_cnt[i] += int'(press[i]);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_press(input logic [N-1:0] m, input string name);
        for (int k = 0; k < 30 && ((press & m) != m); k++) @(negedge clk);
        chk(name, {12'h0, press & m}, {12'h0, m});
    endtask

    int p0;

    initial begin
        for (int i = 0; i < N; i++) press_cnt[i] = 0;
        rst_n = 1'b0;
        btn_n = '1;
        mode  = '0;
        clr   = 1'b0;
        cyc(3);
        #2 rst_n = 1'b1;

        // clean toggle presses: ch0 on, off, on; ch3 on
        for (int r = 0; r < 3; r++) begin
            btn_n[0] = 1'b0; cyc(20);
            btn_n[0] = 1'b1; cyc(20);
        end
        btn_n[3] = 1'b0; cyc(20);
        btn_n[3] = 1'b1; cyc(20);
        chk("ch0_ch3_lit", {12'h0, led}, {12'h0, 4'b0110});

        // bouncing press on ch1, then an isolated short glitch
        p0 = press_cnt[1];
        for (int k = 0; k < 10; k++) begin
            btn_n[1] = (k % 2 == 1); cyc(2);
        end
        btn_n[1] = 1'b0; cyc(20);
        chk("bounce_one_press", 16'(press_cnt[1] - p0), 16'd1);
        btn_n[1] = 1'b1; cyc(20);
        p0 = press_cnt[1];
        btn_n[1] = 1'b0; cyc(3);
        btn_n[1] = 1'b1; cyc(20);
        chk("glitch_no_press", 16'(press_cnt[1] - p0), 16'd0);
        chk("glitch_level", {15'h0, down[1]}, 16'd0);

        // momentary ch2
        mode = 4'b0100;
        btn_n[2] = 1'b0; cyc(10);
        btn_n[2] = 1'b1; cyc(20);

        // clear lands in the same cycle as a ch0 press pulse
        btn_n[0] = 1'b0;
        wait_press(4'b0001, "clr_press_seen");
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        btn_n[0] = 1'b1; cyc(20);
        chk("clr_all_off", {12'h0, led}, {12'h0, 4'hF});

        // all channels pressed on the same edge
        mode  = 4'b0000;
        btn_n = 4'b0000;
        wait_press(4'hF, "all_press_same_cycle");
        cyc(20);
        btn_n = 4'hF; cyc(20);
        chk("all_lit", {12'h0, led}, {12'h0, 4'h0});
        mode[3] = 1'b1;
        cyc(1);
        chk("sw_to_momentary", {15'h0, led[3]}, 16'd1);

        // reset in the middle of a count, button held through release
        btn_n[1] = 1'b0; cyc(3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {led, down, press, rel}, {4'hF, 12'h000});
        cyc(2);
        #2 rst_n = 1'b1;
        wait_press(4'b0010, "repress_after_reset");
        btn_n[1] = 1'b1; cyc(20);

        // randomised traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) btn_n[i] = ~btn_n[i];
            end
            if ($urandom_range(0, 99) == 0) mode = 4'($urandom);
            clr = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 999) == 0) begin
                #2 rst_n = 1'b0;
                cyc(2);
                #2 rst_n = 1'b1;
            end
        end
        clr = 1'b0;
        cyc(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
